i2s_rx: RTL and testbench
=========================

Name: i2s_rx

Overview:
- Serial audio receiver; the receiving end of the I2S link driven by the team's i2s transmitter.
- Recovers 16-bit left/right PCM samples from an external I2S stream (BCK, LRCK, SDATA): an ADC, a loopback from the core's own i2s output, or an inter-board audio link.
- Oversamples all three serial lines in the clk_sys domain, so no second clock exists.
- Delivers parallel stereo samples plus a per-frame strobe to mixers and DAC paths.

Parameters:
- DATA_W, 16, bits captured per channel word (MSB first). Extra slot bits are dropped; fewer bits is an error.
- SYNC_STAGES, 2, synchroniser flops on each of sclk, lrclk and sdata. Minimum value is 2.

Ports:
- clk_sys  in  1  system clock (72 MHz in current cores)
- reset  in  1  asynchronous, active-high reset
- sclk  in  1  I2S bit clock; asynchronous to clk_sys
- lrclk  in  1  I2S word select: 0 = left, 1 = right
- sdata  in  1  I2S serial data
- left_chan  out  DATA_W  last complete left word, two's complement
- right_chan  out  DATA_W  last complete right word, two's complement
- sample_valid  out  1  one-cycle pulse when right_chan updates, which completes a stereo pair
- frame_err  out  1  one-cycle pulse when a slot ends with fewer than DATA_W bits
- locked  out  1  high once the first slot boundary has been seen

Behaviour:
- Reset is asynchronous and active-high. It clears:
  - all synchroniser flops, the shift register, the bit counter and the word-channel flag;
  - left_chan and right_chan to 0;
  - sample_valid, frame_err and locked to 0;
  - the state, to IDLE.
  Reset asserted mid-word discards the partial word. No output changes until a new boundary is seen after reset is released.
- Synchronisation: sclk, lrclk and sdata each pass through SYNC_STAGES flops with equal delay, so they stay mutually aligned.
- Bit event: synced sclk = 1 while the previous synced sclk = 0. Only bit events advance the logic.
- Boundary: a bit event at which synced lrclk differs from the lrclk value registered at the previous bit event.
- Timing requirement: each sclk phase must last at least SYNC_STAGES+1 clk_sys cycles. Faster streams are unsupported; behaviour is undefined.
- States:
  - IDLE: bits are ignored. On a boundary: bit_cnt := 0, word channel := new lrclk, locked := 1, go to SHIFT.
  - SHIFT, on a non-boundary bit event: if bit_cnt < DATA_W, shift sdata into the LSB and increment bit_cnt; otherwise discard the bit.
  - SHIFT, on a boundary, in this order:
    - the boundary bit belongs to the ending word (I2S one-bit delay), so shift it in if bit_cnt < DATA_W;
    - if bit_cnt now equals DATA_W, commit the word to the channel given by the word-channel flag;
    - otherwise pulse frame_err and discard the word;
    - then bit_cnt := 0 and word channel := new lrclk.
  - The state stays SHIFT until reset.
- Bit ordering: the first bit after a boundary is the MSB.
- Slot length:
  - a DATA_W-bit slot completes exactly on its closing boundary;
  - for longer slots (24 or 32 bits), the top DATA_W bits are kept and the remainder dropped.
- Commit:
  - the output register loads on the same clk_sys edge that processes the final bit;
  - latency from the sclk pin edge to the output change is SYNC_STAGES+1 clk_sys cycles.
- sample_valid is asserted in the same cycle as a right-word commit. A left commit alone never pulses it.
- Outputs hold their last value between commits and when a word is discarded.
- sample_valid and frame_err never assert in the same cycle, because only one word ends per boundary.
- Target size: 120-250 lines of RTL.

Test Plan:
- 16-bit slots, BCK = clk_sys/24, left 0x8001, right 0x7FFE, 4 frames -> left_chan = 0x8001, right_chan = 0x7FFE, exactly 4 sample_valid pulses, each lagging the closing boundary sclk rise by 3 clk_sys cycles; frame_err never asserts.
- 32-bit slots, left 0x1234_5678, right 0xFEDC_BA98 -> left_chan = 0x1234, right_chan = 0xFEDC, one sample_valid per frame.
- Stream starts mid-slot after reset -> locked rises at the first boundary; the partial word is not committed; the first commit is a full word.
- One 8-bit left slot inserted between valid 16-bit frames -> one frame_err pulse; left_chan keeps its previous value; the next full frame commits normally.
- Reset asserted for one cycle mid-right-word after a valid frame -> outputs 0 at once, locked = 0; the following frame is only committed after a fresh boundary.
- Right word completes, with left = 0xFFFF and right = 0x0000 -> sample_valid coincides with the right_chan update; left_chan updates one slot earlier without a pulse.

Source files
------------

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples sclk/lrclk/sdata in clk_sys and emits DATA_W-bit left/right words.
// Latency: sclk pin rise to output register change is SYNC_STAGES+1 clk_sys cycles; no backpressure.
`timescale 1ns/1ps
module i2s_rx #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              sclk,
    input  logic              lrclk,
    input  logic              sdata,
    output logic [DATA_W-1:0] left_chan,
    output logic [DATA_W-1:0] right_chan,
    output logic              sample_valid,
    output logic              frame_err,
    output logic              locked
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                   state, state_nxt;
    logic [SYNC_STAGES-1:0]   sclk_sync, lr_sync, sd_sync;
    logic                     sclk_s, lr_s, sd_s;
    logic                     sclk_d, lr_last;
    logic [DATA_W-1:0]        shreg, shifted, word_nxt;
    logic [CNT_W-1:0]         bit_cnt;
    logic                     word_ch;
    logic                     bit_evt, boundary, can_shift, word_full;
    logic                     do_shift, do_commit, do_err, restart;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign lr_s      = lr_sync[SYNC_STAGES-1];
    assign sd_s      = sd_sync[SYNC_STAGES-1];
    assign bit_evt   = sclk_s & ~sclk_d;
    assign boundary  = bit_evt & (lr_s != lr_last);
    assign can_shift = (bit_cnt < CNT_W'(DATA_W));
    assign shifted   = {shreg[DATA_W-2:0], sd_s};
    // The closing boundary bit still belongs to the ending word, so a word
    // holding DATA_W-1 bits at the boundary is complete once that bit lands.
    assign word_full = (bit_cnt == CNT_W'(DATA_W)) || (bit_cnt == CNT_W'(DATA_W - 1));
    assign word_nxt  = can_shift ? shifted : shreg;

    always_comb begin
        state_nxt = state;
        do_shift  = 1'b0;
        do_commit = 1'b0;
        do_err    = 1'b0;
        restart   = 1'b0;
        case (state)
            IDLE: begin
                if (boundary) begin
                    restart   = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_evt && can_shift) begin
                    do_shift = 1'b1;
                end
                if (boundary) begin
                    restart   = 1'b1;
                    do_commit = word_full;
                    do_err    = ~word_full;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sclk_sync    <= '0;
            lr_sync      <= '0;
            sd_sync      <= '0;
            sclk_d       <= 1'b0;
            lr_last      <= 1'b0;
            shreg        <= '0;
            bit_cnt      <= '0;
            word_ch      <= 1'b0;
            left_chan    <= '0;
            right_chan   <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            locked       <= 1'b0;
        end else begin
            sclk_sync    <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            lr_sync      <= {lr_sync[SYNC_STAGES-2:0], lrclk};
            sd_sync      <= {sd_sync[SYNC_STAGES-2:0], sdata};
            sclk_d       <= sclk_s;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            if (bit_evt) begin
                lr_last <= lr_s;
            end
            if (do_shift) begin
                shreg   <= shifted;
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (restart) begin
                bit_cnt <= '0;
                word_ch <= lr_s;
                locked  <= 1'b1;
            end
            if (do_commit) begin
                if (word_ch) begin
                    right_chan   <= word_nxt;
                    sample_valid <= 1'b1;
                end else begin
                    left_chan <= word_nxt;
                end
            end
            if (do_err) begin
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: drives I2S frames with a one-bit lrclk lead and checks commits against a slot-level model.
`timescale 1ns/1ps
module tb_i2s_rx;
    localparam int DW = 16;

    logic          clk_sys = 1'b0;
    logic          reset   = 1'b0;
    logic          sclk    = 1'b0;
    logic          lrclk   = 1'b0;
    logic          sdata   = 1'b0;
    logic [DW-1:0] left_chan, right_chan;
    logic          sample_valid, frame_err, locked;

    i2s_rx #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .sclk         (sclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .left_chan    (left_chan),
        .right_chan   (right_chan),
        .sample_valid (sample_valid),
        .frame_err    (frame_err),
        .locked       (locked)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected pulse events: kind 1 = right commit (sample_valid), 2 = frame_err.
    typedef struct {
        int            kind;
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } ev_t;
    ev_t exp_q[$];

    // Slot-level reference model state.
    bit            m_prev_lr;
    bit            m_locked;
    bit            m_open_ch;
    int            m_len;
    logic [31:0]   m_word;
    logic [DW-1:0] m_left, m_right;

    int  half = 12;
    bit  last_bit;
    bit  drv_prev_lr;
    int  bound_cyc = 0;
    int  n_valid = 0;
    int  n_err = 0;
    bit  mon_en = 1'b0;
    logic [DW-1:0] left_prev = '0;

    task automatic model_reset();
        m_prev_lr   = 1'b0;
        m_locked    = 1'b0;
        m_open_ch   = 1'b0;
        m_len       = 0;
        m_word      = '0;
        m_left      = '0;
        m_right     = '0;
        drv_prev_lr = 1'b0;
        last_bit    = 1'b0;
        exp_q.delete();
    endtask

    // A slot starting on a changed lrclk closes the previous slot; if the
    // receiver was already locked, that slot either commits its top bits or errors.
    task automatic model_slot_start(input bit ch);
        logic [31:0] v;
        if (ch != m_prev_lr) begin
            if (m_locked) begin
                if (m_len >= DW) begin
                    v = m_word >> (m_len - DW);
                    if (m_open_ch) begin
                        m_right = v[DW-1:0];
                        exp_q.push_back('{kind: 1, l: m_left, r: m_right});
                    end else begin
                        m_left = v[DW-1:0];
                    end
                end else begin
                    exp_q.push_back('{kind: 2, l: m_left, r: m_right});
                end
            end
            m_locked  = 1'b1;
            m_open_ch = ch;
        end
        m_prev_lr = ch;
    endtask

    task automatic drive_period(input bit lr, input bit sd);
        @(posedge clk_sys); #2;
        sclk  = 1'b0;
        lrclk = lr;
        sdata = sd;
        repeat (half) @(posedge clk_sys);
        #2;
        sclk = 1'b1;
        if (lr != drv_prev_lr) bound_cyc = cyc;
        drv_prev_lr = lr;
        repeat (half - 1) @(posedge clk_sys);
    endtask

    task automatic send_slot(input bit ch, input int len, input logic [31:0] word);
        model_slot_start(ch);
        m_len  = len;
        m_word = word;
        for (int k = 0; k < len; k++) begin
            drive_period(ch, last_bit);
            last_bit = word[len-1-k];
        end
    endtask

    task automatic send_term(input bit ch);
        model_slot_start(ch);
        m_len  = 0;
        m_word = '0;
        drive_period(ch, last_bit);
        repeat (6) @(posedge clk_sys);
    endtask

    task automatic do_reset();
        @(posedge clk_sys); #2;
        sclk = 1'b0;
        repeat (4) @(posedge clk_sys);
        #2 reset = 1'b1;
        @(posedge clk_sys);
        #2 reset = 1'b0;
        model_reset();
    endtask

    task automatic end_scenario(input string name);
        check({name, "_pending_events"}, exp_q.size(), 0);
        check({name, "_left_final"}, left_chan, m_left);
        check({name, "_right_final"}, right_chan, m_right);
        exp_q.delete();
    endtask

    always @(negedge clk_sys) begin
        ev_t e;
        if (mon_en && !reset) begin
            if (sample_valid) begin
                n_valid++;
                check("valid_without_err", frame_err, 1'b0);
                check("left_stable_on_valid", left_chan, left_prev);
            end
            if (frame_err) n_err++;
            if (sample_valid || frame_err) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: valid=%0b err=%0b left=%0h right=%0h with none expected",
                             sample_valid, frame_err, left_chan, right_chan);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", sample_valid ? 1 : 2, e.kind);
                    check("left_at_pulse", left_chan, e.l);
                    check("right_at_pulse", right_chan, e.r);
                    check("pulse_latency", cyc - bound_cyc, 3);
                end
            end
        end
        left_prev <= left_chan;
    end

    typedef struct {
        logic [31:0]   lw;
        logic [31:0]   rw;
        int            len;
        int            frames;
        int            hp;
        logic [DW-1:0] exp_l;
        logic [DW-1:0] exp_r;
        int            exp_valid;
    } vec_t;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[4];
        int   v0, e0;
        bit   ch;
        int   nslots, len, p;
        logic [31:0] w;

        tbl[0] = '{lw: 32'h8001,      rw: 32'h7FFE,      len: 16, frames: 4, hp: 12, exp_l: 16'h8001, exp_r: 16'h7FFE, exp_valid: 4};
        tbl[1] = '{lw: 32'h1234_5678, rw: 32'hFEDC_BA98, len: 32, frames: 2, hp: 12, exp_l: 16'h1234, exp_r: 16'hFEDC, exp_valid: 2};
        tbl[2] = '{lw: 32'hFFFF,      rw: 32'h0000,      len: 16, frames: 2, hp: 12, exp_l: 16'hFFFF, exp_r: 16'h0000, exp_valid: 2};
        tbl[3] = '{lw: 32'hAB_CDEF,   rw: 32'h12_3456,   len: 24, frames: 2, hp: 8,  exp_l: 16'hABCD, exp_r: 16'h1234, exp_valid: 2};

        model_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        check("reset_left", left_chan, 16'h0);
        check("reset_right", right_chan, 16'h0);
        check("reset_valid", sample_valid, 1'b0);
        check("reset_err", frame_err, 1'b0);
        check("reset_locked", locked, 1'b0);
        #1 reset = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 4; i++) begin
            do_reset();
            half = tbl[i].hp;
            v0 = n_valid;
            e0 = n_err;
            for (int f = 0; f < tbl[i].frames; f++) begin
                send_slot(1'b0, tbl[i].len, tbl[i].lw);
                send_slot(1'b1, tbl[i].len, tbl[i].rw);
            end
            send_term(1'b0);
            check("tbl_left", left_chan, tbl[i].exp_l);
            check("tbl_right", right_chan, tbl[i].exp_r);
            check("tbl_valid_count", n_valid - v0, tbl[i].exp_valid);
            check("tbl_err_count", n_err - e0, 0);
            end_scenario("tbl");
        end

        // Stream begins partway through a left slot.
        half = 6;
        do_reset();
        send_slot(1'b0, 7, 32'h55);
        check("midslot_unlocked", locked, 1'b0);
        send_slot(1'b1, 16, 32'h1111);
        check("midslot_locked", locked, 1'b1);
        v0 = n_valid;
        send_slot(1'b0, 16, 32'h2222);
        check("midslot_first_commit", right_chan, 16'h1111);
        send_slot(1'b1, 16, 32'h3333);
        send_term(1'b0);
        check("midslot_valid_count", n_valid - v0, 2);
        end_scenario("midslot");

        // Short left slot between valid frames.
        do_reset();
        e0 = n_err;
        send_slot(1'b0, 16, 32'h1357);
        send_slot(1'b1, 16, 32'h5A5A);
        send_slot(1'b0, 16, 32'hA5A5);
        send_slot(1'b1, 16, 32'h2468);
        send_slot(1'b0, 8,  32'h3C);
        send_slot(1'b1, 16, 32'h0F0F);
        check("short_left_held", left_chan, 16'hA5A5);
        send_slot(1'b0, 16, 32'hC3C3);
        send_slot(1'b1, 16, 32'h9999);
        send_term(1'b0);
        check("short_err_count", n_err - e0, 1);
        check("short_left_after", left_chan, 16'hC3C3);
        check("short_right_after", right_chan, 16'h9999);
        end_scenario("short");

        // Reset pulse in the middle of a right word.
        do_reset();
        send_slot(1'b0, 16, 32'h4321);
        send_slot(1'b1, 16, 32'h8765);
        send_slot(1'b0, 16, 32'hBEEF);
        send_slot(1'b1, 8,  32'hA5);
        @(posedge clk_sys); #2;
        sclk = 1'b0;
        repeat (4) @(posedge clk_sys);
        #2 reset = 1'b1;
        #1;
        check("midreset_left", left_chan, 16'h0);
        check("midreset_right", right_chan, 16'h0);
        check("midreset_locked", locked, 1'b0);
        @(posedge clk_sys);
        #2 reset = 1'b0;
        model_reset();
        send_slot(1'b1, 8,  32'h5A);
        send_slot(1'b0, 16, 32'h7777);
        send_slot(1'b1, 16, 32'h6666);
        send_term(1'b0);
        end_scenario("midreset");

        // Random slot lengths, data and bit-clock rates.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            half   = $urandom_range(4, 9);
            nslots = $urandom_range(8, 14);
            ch     = 1'b0;
            for (int s = 0; s < nslots; s++) begin
                p = $urandom_range(0, 9);
                if (p < 2)      len = $urandom_range(8, 15);
                else if (p < 6) len = 16;
                else if (p < 8) len = 24;
                else            len = 32;
                w = $urandom;
                if (len < 32) w = w & ((32'd1 << len) - 32'd1);
                send_slot(ch, len, w);
                ch = ~ch;
            end
            send_term(ch);
            end_scenario("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
